// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//
// Parametrised up/down counter with modulus, count enable, synchronous
// parallel load, combinational terminal count and registered wrap pulses.
// The count sequence is 0..MOD_MAX. WIDTH is legal in 2..32.
// MOD_MAX must satisfy 1 <= MOD_MAX <= 2**WIDTH-1.
//
// Optional feature, enabled by defining the macro COUNTER_SATURATE_EN:
//   adds input Sat (clamp at the ends instead of wrapping) and a sticky
//   registered output SatHit. The sticky flag is set by any clamp and is
//   cleared only by reset or Load. Without the macro the counter always wraps.
//
// Update priority on each rising Clk edge: reset > Load > En > hold.
// -----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}}
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             En,
    input  logic             UpOrDown,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
`ifdef COUNTER_SATURATE_EN
    input  logic             Sat,
    output logic             SatHit,
`endif
    output logic [WIDTH-1:0] Count,
    output logic             TermCnt,
    output logic             WrapUp,
    output logic             WrapDown
);

    // Modulus and constants widened by one bit so that MOD_MAX = 2**WIDTH-1
    // can be compared against an incremented value without overflow.
    localparam logic [WIDTH:0] MOD_MAX_EXT = {1'b0, MOD_MAX};
    localparam logic [WIDTH:0] ONE_EXT     = {{WIDTH{1'b0}}, 1'b1};

    // Loads above the modulus are clamped to MOD_MAX so the count never
    // leaves the legal sequence.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] res;
        if ({1'b0, val} > MOD_MAX_EXT) begin
            res = MOD_MAX;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // State registers
    logic [WIDTH-1:0] count_r;
    logic             wrap_up_r;
    logic             wrap_dn_r;

    // Next-state and datapath signals
    logic [WIDTH-1:0] count_nxt_s;
    logic             wrap_up_nxt_s;
    logic             wrap_dn_nxt_s;
    logic [WIDTH:0]   count_ext_s;
    logic [WIDTH:0]   inc_ext_s;
    logic [WIDTH:0]   dec_ext_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             sat_mode_s;

    // Arithmetic is done one bit wider than the count. An increment that
    // exceeds the modulus means the count sits at MOD_MAX; a decrement that
    // borrows out of the top bit means the count sits at zero.
    assign count_ext_s = {1'b0, count_r};
    assign inc_ext_s   = count_ext_s + ONE_EXT;
    assign dec_ext_s   = count_ext_s - ONE_EXT;
    assign at_max_s    = (inc_ext_s > MOD_MAX_EXT);
    assign at_zero_s   = dec_ext_s[WIDTH];

`ifdef COUNTER_SATURATE_EN
    assign sat_mode_s = Sat;
`else
    assign sat_mode_s = 1'b0;
`endif

    // Next-state selection for the count and the wrap pulses.
    always_comb begin
        count_nxt_s   = count_r;
        wrap_up_nxt_s = 1'b0;
        wrap_dn_nxt_s = 1'b0;
        if (Load) begin
            count_nxt_s = clamp_load(LoadVal);
        end else if (En) begin
            if (UpOrDown) begin
                if (at_max_s) begin
                    if (sat_mode_s) begin
                        count_nxt_s = MOD_MAX;
                    end else begin
                        count_nxt_s   = {WIDTH{1'b0}};
                        wrap_up_nxt_s = 1'b1;
                    end
                end else begin
                    count_nxt_s = inc_ext_s[WIDTH-1:0];
                end
            end else begin
                if (at_zero_s) begin
                    if (sat_mode_s) begin
                        count_nxt_s = {WIDTH{1'b0}};
                    end else begin
                        count_nxt_s   = MOD_MAX;
                        wrap_dn_nxt_s = 1'b1;
                    end
                end else begin
                    count_nxt_s = dec_ext_s[WIDTH-1:0];
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count and wrap-pulse registers with asynchronous reset.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            count_r   <= {WIDTH{1'b0}};
            wrap_up_r <= 1'b0;
            wrap_dn_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            wrap_up_r <= wrap_up_nxt_s;
            wrap_dn_r <= wrap_dn_nxt_s;
        end
    end

`ifdef COUNTER_SATURATE_EN
    logic sat_hit_r;
    logic sat_hit_nxt_s;
    logic clamp_s;

    // A clamp is a counting step that would have wrapped while Sat is set.
    assign clamp_s = ~Load & En & Sat & (UpOrDown ? at_max_s : at_zero_s);

    // Sticky clamp flag: Load clears it, a clamp sets it, otherwise it holds.
    always_comb begin
        sat_hit_nxt_s = sat_hit_r;
        if (Load) begin
            sat_hit_nxt_s = 1'b0;
        end else if (clamp_s) begin
            sat_hit_nxt_s = 1'b1;
        end else begin
            sat_hit_nxt_s = sat_hit_r;
        end
    end

    // Sticky clamp register with asynchronous reset.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sat_hit_r <= 1'b0;
        end else begin
            sat_hit_r <= sat_hit_nxt_s;
        end
    end

    assign SatHit = sat_hit_r;
`endif

    // Terminal count looks one step ahead: high in the cycle before a wrap
    // (or clamp) would occur on the next edge.
    assign TermCnt  = En & ~Load & (UpOrDown ? at_max_s : at_zero_s);

    assign Count    = count_r;
    assign WrapUp   = wrap_up_r;
    assign WrapDown = wrap_dn_r;

endmodule

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
//
// Directed bench for updown_counter_param with WIDTH=4, MOD_MAX=9.
// Build with COUNTER_SATURATE_EN defined to also exercise Sat/SatHit.
// -----------------------------------------------------------------------------
module tb_updown_counter_param;

    logic       Clk;
    logic       reset;
    logic       En;
    logic       UpOrDown;
    logic       Load;
    logic [3:0] LoadVal;
    logic [3:0] Count;
    logic       TermCnt;
    logic       WrapUp;
    logic       WrapDown;
`ifdef COUNTER_SATURATE_EN
    logic       Sat;
    logic       SatHit;
`endif

    int n_checks;
    int n_fail;
    int exp_cnt;
    int prev_cnt;

    updown_counter_param #(
        .WIDTH   (4),
        .MOD_MAX (4'd9)
    ) dut (
        .Clk      (Clk),
        .reset    (reset),
        .En       (En),
        .UpOrDown (UpOrDown),
        .Load     (Load),
        .LoadVal  (LoadVal),
`ifdef COUNTER_SATURATE_EN
        .Sat      (Sat),
        .SatHit   (SatHit),
`endif
        .Count    (Count),
        .TermCnt  (TermCnt),
        .WrapUp   (WrapUp),
        .WrapDown (WrapDown)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Counts every comparison and reports any mismatch.
    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        En       = 1'b0;
        UpOrDown = 1'b0;
        Load     = 1'b0;
        LoadVal  = 4'd0;
`ifdef COUNTER_SATURATE_EN
        Sat      = 1'b0;
`endif
        #12;
        check_value("rst_count",   32'(Count),    32'd0);
        check_value("rst_wrapup",  32'(WrapUp),   32'd0);
        check_value("rst_wrapdn",  32'(WrapDown), 32'd0);
        check_value("rst_termcnt", 32'(TermCnt),  32'd0);

        // 1: count up 12 edges from 0 -> 1..9,0,1,2
        reset    = 1'b0;
        En       = 1'b1;
        UpOrDown = 1'b1;
        exp_cnt  = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            check_value("up_termcnt", 32'(TermCnt), (exp_cnt == 9) ? 32'd1 : 32'd0);
            prev_cnt = exp_cnt;
            exp_cnt  = (exp_cnt == 9) ? 0 : exp_cnt + 1;
            tick();
            check_value("up_count",  32'(Count),    32'(exp_cnt));
            check_value("up_wrapup", 32'(WrapUp),   (prev_cnt == 9) ? 32'd1 : 32'd0);
            check_value("up_wrapdn", 32'(WrapDown), 32'd0);
        end

        // 2: load 0, then count down 3 edges -> 9,8,7
        Load    = 1'b1;
        LoadVal = 4'd0;
        tick();
        check_value("ld0_count", 32'(Count), 32'd0);
        Load     = 1'b0;
        UpOrDown = 1'b0;
        #1;
        check_value("dn_termcnt_at0", 32'(TermCnt), 32'd1);
        tick();
        check_value("dn_count_9",  32'(Count),    32'd9);
        check_value("dn_wrapdn_9", 32'(WrapDown), 32'd1);
        check_value("dn_wrapup_9", 32'(WrapUp),   32'd0);
        check_value("dn_termcnt_9", 32'(TermCnt), 32'd0);
        tick();
        check_value("dn_count_8",  32'(Count),    32'd8);
        check_value("dn_wrapdn_8", 32'(WrapDown), 32'd0);
        tick();
        check_value("dn_count_7",  32'(Count),    32'd7);

        // 3: load above modulus clamps; load wins over En
        En      = 1'b0;
        Load    = 1'b1;
        LoadVal = 4'd12;
        tick();
        check_value("ld12_count", 32'(Count), 32'd9);
        En       = 1'b1;
        UpOrDown = 1'b1;
        LoadVal  = 4'd3;
        #1;
        check_value("ld_termcnt_masked", 32'(TermCnt), 32'd0);
        tick();
        check_value("ld3_count",  32'(Count),  32'd3);
        check_value("ld3_wrapup", 32'(WrapUp), 32'd0);

        // 4: count up to 6, then asynchronous reset mid-cycle
        Load = 1'b0;
        tick();
        tick();
        tick();
        check_value("pre_rst_count", 32'(Count), 32'd6);
        #3;
        reset = 1'b1;
        #1;
        check_value("async_rst_count",  32'(Count),    32'd0);
        check_value("async_rst_wrapup", 32'(WrapUp),   32'd0);
        check_value("async_rst_wrapdn", 32'(WrapDown), 32'd0);
        #1;
        reset = 1'b0;
        tick();
        check_value("resume_count_1", 32'(Count), 32'd1);
        tick();
        check_value("resume_count_2", 32'(Count), 32'd2);
        tick();
        tick();
        check_value("resume_count_4", 32'(Count), 32'd4);

        // 5: hold with En=0 while direction toggles, then direction change
        En = 1'b0;
        for (int i = 0; i < 5; i++) begin
            UpOrDown = ~UpOrDown;
            #1;
            check_value("hold_termcnt", 32'(TermCnt), 32'd0);
            tick();
            check_value("hold_count",  32'(Count),    32'd4);
            check_value("hold_wrapup", 32'(WrapUp),   32'd0);
            check_value("hold_wrapdn", 32'(WrapDown), 32'd0);
        end
        En       = 1'b1;
        UpOrDown = 1'b1;
        tick();
        check_value("dir_up_count", 32'(Count), 32'd5);
        UpOrDown = 1'b0;
        tick();
        check_value("dir_dn_count", 32'(Count), 32'd4);

`ifdef COUNTER_SATURATE_EN
        // 6: saturation clamps at MOD_MAX and at zero, SatHit is sticky
        En      = 1'b0;
        Load    = 1'b1;
        LoadVal = 4'd9;
        tick();
        check_value("sat_pre_hit", 32'(SatHit), 32'd0);
        Load     = 1'b0;
        En       = 1'b1;
        UpOrDown = 1'b1;
        Sat      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_value("sat_termcnt", 32'(TermCnt), 32'd1);
            tick();
            check_value("sat_count",  32'(Count),  32'd9);
            check_value("sat_wrapup", 32'(WrapUp), 32'd0);
            check_value("sat_hit",    32'(SatHit), 32'd1);
        end
        En = 1'b0;
        tick();
        check_value("sat_hit_sticky", 32'(SatHit), 32'd1);
        Load    = 1'b1;
        LoadVal = 4'd2;
        tick();
        check_value("sat_ld_count", 32'(Count),  32'd2);
        check_value("sat_ld_hit",   32'(SatHit), 32'd0);
        Load    = 1'b0;
        LoadVal = 4'd0;
        Load    = 1'b1;
        tick();
        Load     = 1'b0;
        En       = 1'b1;
        UpOrDown = 1'b0;
        tick();
        check_value("sat_dn_count",  32'(Count),    32'd0);
        check_value("sat_dn_wrapdn", 32'(WrapDown), 32'd0);
        check_value("sat_dn_hit",    32'(SatHit),   32'd1);
        Sat = 1'b0;
        tick();
        check_value("nosat_dn_count",  32'(Count),    32'd9);
        check_value("nosat_dn_wrapdn", 32'(WrapDown), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
